// File: rtl/sample_sequencer.sv
// sample_sequencer: walks a word region of flash one 32-bit word at a time and
// plays each word as two 16-bit samples on successive audio ticks.
// Optional build macro SAMPLE_SEQUENCER_REVERSE_EN enables reverse playback;
// without it direction is ignored and playback is forward only.
//
// Reader handshake: reader_start is a one-cycle request (high only in FETCH)
// for the word at word_addr; the reader answers later with a one-cycle
// reader_finish carrying reader_data. At most one request is outstanding, and
// a reader_finish seen outside WAIT is ignored.
module sample_sequencer #(
    parameter logic [22:0] START_ADDR = 23'h000000,
    parameter logic [22:0] END_ADDR   = 23'h07FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play,
    input  logic        direction,
    input  logic        restart,
    input  logic        sample_tick,
    output logic        reader_start,
    output logic        reader_addr_old,
    input  logic        reader_finish,
    input  logic [31:0] reader_data,
    output logic [22:0] word_addr,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic [7:0]  underrun_cnt,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        TICK0 = 3'd3,
        TICK1 = 3'd4
    } state_t;

    state_t      state, state_d;
    logic [31:0] word_buf, buf_d;
    logic [22:0] last_addr, last_addr_d;
    logic        last_valid, last_valid_d;
    logic        restart_pend, pend_d;
    logic [22:0] addr_d;
    logic [15:0] sample_d;
    logic        valid_d;
    logic [7:0]  under_d;
    logic        fwd;
    logic [22:0] advance_addr;
    logic [22:0] reload_addr;

`ifdef SAMPLE_SEQUENCER_REVERSE_EN
    assign fwd         = direction;
    assign reload_addr = fwd ? START_ADDR : END_ADDR;

    // Next word address in the current direction, wrapping at the region ends.
    always_comb begin
        if (fwd) begin
            advance_addr = (word_addr == END_ADDR) ? START_ADDR : word_addr + 23'd1;
        end else begin
            advance_addr = (word_addr == START_ADDR) ? END_ADDR : word_addr - 23'd1;
        end
    end
`else
    logic unused_direction;
    assign unused_direction = direction;
    assign fwd              = 1'b1;
    assign reload_addr      = START_ADDR;
    assign advance_addr     = (word_addr == END_ADDR) ? START_ADDR : word_addr + 23'd1;
`endif

    assign reader_start    = (state == FETCH);
    assign reader_addr_old = (state == FETCH) && last_valid && (word_addr == last_addr);
    assign dbg_state       = state;

    // Next-state and datapath decode; every target defaults to holding.
    always_comb begin
        state_d      = state;
        addr_d       = word_addr;
        buf_d        = word_buf;
        last_addr_d  = last_addr;
        last_valid_d = last_valid;
        pend_d       = restart_pend;
        sample_d     = sample_out;
        valid_d      = 1'b0;
        under_d      = underrun_cnt;

        case (state)
            IDLE: begin
                if (restart) begin
                    addr_d       = reload_addr;
                    last_valid_d = 1'b0;
                end else if (play) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (restart) pend_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (restart) pend_d = 1'b1;
                if (reader_finish) begin
                    // A restart seen during the fetch wins over the returned data.
                    if (restart_pend || restart) begin
                        pend_d       = 1'b0;
                        addr_d       = reload_addr;
                        last_valid_d = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        buf_d        = reader_data;
                        last_addr_d  = word_addr;
                        last_valid_d = 1'b1;
                        state_d      = TICK0;
                    end
                end
            end
            TICK0: begin
                if (restart) begin
                    addr_d       = reload_addr;
                    last_valid_d = 1'b0;
                    state_d      = IDLE;
                end else if (play && sample_tick) begin
                    sample_d = fwd ? word_buf[15:0] : word_buf[31:16];
                    valid_d  = 1'b1;
                    state_d  = TICK1;
                end
            end
            TICK1: begin
                if (restart) begin
                    addr_d       = reload_addr;
                    last_valid_d = 1'b0;
                    state_d      = IDLE;
                end else if (play && sample_tick) begin
                    sample_d = fwd ? word_buf[31:16] : word_buf[15:0];
                    valid_d  = 1'b1;
                    addr_d   = advance_addr;
                    state_d  = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A tick that lands while a word is still being fetched is lost.
        if ((state == FETCH || state == WAIT) && play && sample_tick &&
            (underrun_cnt != 8'hFF)) begin
            under_d = underrun_cnt + 8'd1;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            word_addr    <= START_ADDR;
            word_buf     <= 32'd0;
            last_addr    <= 23'd0;
            last_valid   <= 1'b0;
            restart_pend <= 1'b0;
            sample_out   <= 16'd0;
            sample_valid <= 1'b0;
            underrun_cnt <= 8'd0;
        end else begin
            state        <= state_d;
            word_addr    <= addr_d;
            word_buf     <= buf_d;
            last_addr    <= last_addr_d;
            last_valid   <= last_valid_d;
            restart_pend <= pend_d;
            sample_out   <= sample_d;
            sample_valid <= valid_d;
            underrun_cnt <= under_d;
        end
    end

endmodule

// File: tb/tb_sample_sequencer.sv
// tb_sample_sequencer: directed scenarios plus randomized play against a
// transaction-level model of the sample sequencer. A small region is used so
// that address wrap is reachable in a short run.
module tb_sample_sequencer;

    localparam logic [22:0] S_A = 23'h000000;
    localparam logic [22:0] E_A = 23'h00000F;
    localparam int          N_W = 16;
`ifdef SAMPLE_SEQUENCER_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        rst_n, play, direction, restart, sample_tick;
    logic        reader_start, reader_addr_old, reader_finish;
    logic [31:0] reader_data;
    logic [22:0] word_addr;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic [7:0]  underrun_cnt;
    logic [2:0]  dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sample_sequencer #(.START_ADDR(S_A), .END_ADDR(E_A)) dut (
        .clk(clk), .rst_n(rst_n), .play(play), .direction(direction),
        .restart(restart), .sample_tick(sample_tick),
        .reader_start(reader_start), .reader_addr_old(reader_addr_old),
        .reader_finish(reader_finish), .reader_data(reader_data),
        .word_addr(word_addr), .sample_out(sample_out),
        .sample_valid(sample_valid), .underrun_cnt(underrun_cnt),
        .dbg_state(dbg_state)
    );

    // ---------------- counters ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int start_cnt = 0;
    int valid_cnt = 0;

    // ---------------- drive variables ----------------
    bit          rst_v = 1'b0, play_v = 1'b0, dir_v = 1'b1, restart_v = 1'b0, tick_v = 1'b0;
    bit          stray_en = 1'b0, rand_lat = 1'b0, rand_word = 1'b0;
    int          lat_v = 3;
    logic [31:0] word_v = 32'h0;

    // reader responder state
    bit          rd_busy = 1'b0;
    int          rd_cnt = 0;
    logic [31:0] rd_word = 32'h0;

    // ---------------- behavioural model ----------------
    // m_active: left idle; m_issue: request goes out this cycle;
    // m_busy: request outstanding; m_left: halves still to play from m_buf.
    bit          m_active, m_issue, m_busy, m_pend, m_last_valid, m_valid;
    int          m_left;
    logic [22:0] m_addr, m_last_addr;
    logic [31:0] m_buf;
    logic [15:0] m_out;
    logic [7:0]  m_under;

    function automatic logic [22:0] wrap_add(input logic [22:0] a, input int delta);
        int off;
        off = (int'(a) - int'(S_A) + delta + N_W) % N_W;
        return S_A + 23'(off);
    endfunction

    task automatic m_reset();
        m_active = 0; m_issue = 0; m_busy = 0; m_pend = 0; m_last_valid = 0;
        m_valid = 0; m_left = 0; m_addr = S_A; m_last_addr = '0; m_buf = '0;
        m_out = '0; m_under = '0;
    endtask

    task automatic m_reload(input bit fwd);
        m_addr = fwd ? S_A : E_A;
        m_last_valid = 0;
    endtask

    task automatic m_step(input bit p, input bit d, input bit rs, input bit tk,
                          input bit fin, input logic [31:0] data);
        bit fwd;
        bit low;
        fwd = REV ? d : 1'b1;
        m_valid = 0;
        if (!m_active) begin
            if (rs) m_reload(fwd);
            else if (p) begin m_active = 1; m_issue = 1; end
        end else if (m_issue || m_busy) begin
            if (tk && p && m_under != 8'hFF) m_under = m_under + 8'd1;
            if (rs) m_pend = 1;
            if (m_issue) begin
                m_issue = 0; m_busy = 1;
            end else if (fin) begin
                m_busy = 0;
                if (m_pend) begin
                    m_pend = 0; m_reload(fwd); m_active = 0;
                end else begin
                    m_buf = data; m_last_addr = m_addr; m_last_valid = 1; m_left = 2;
                end
            end
        end else begin
            if (rs) begin
                m_reload(fwd); m_active = 0; m_left = 0;
            end else if (p && tk) begin
                low = (m_left == 2) ? fwd : !fwd;
                m_out = low ? m_buf[15:0] : m_buf[31:16];
                m_valid = 1;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_addr = wrap_add(m_addr, fwd ? 1 : -1);
                    m_issue = 1;
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic compare_all();
        logic [49:0] exp_v, act_v;
        logic        exp_old;
        exp_old = m_issue && m_last_valid && (m_addr == m_last_addr);
        exp_v = {m_issue, exp_old, m_addr, m_out, m_valid, m_under};
        act_v = {reader_start, reader_addr_old, word_addr, sample_out, sample_valid, underrun_cnt};
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t got rs=%b old=%b addr=%h out=%h v=%b und=%h want rs=%b old=%b addr=%h out=%h v=%b und=%h",
                     $time, reader_start, reader_addr_old, word_addr, sample_out, sample_valid,
                     underrun_cnt, m_issue, exp_old, m_addr, m_out, m_valid, m_under);
        end
    endtask

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step();
        logic        fin;
        logic [31:0] data;
        @(negedge clk);
        compare_all();
        if (reader_start === 1'b1) start_cnt++;
        if (sample_valid === 1'b1) valid_cnt++;
        fin  = 1'b0;
        data = $urandom;
        if (!rst_v) begin
            rd_busy = 0;
        end else begin
            if (rd_busy) begin
                rd_cnt--;
                if (rd_cnt <= 0) begin fin = 1'b1; data = rd_word; rd_busy = 0; end
            end else if (stray_en && $urandom_range(0, 15) == 0) begin
                fin = 1'b1;
            end
            if (reader_start === 1'b1) begin
                rd_busy = 1;
                rd_cnt  = rand_lat ? int'($urandom_range(1, 12)) : lat_v;
                rd_word = rand_word ? 32'($urandom) : word_v;
            end
        end
        rst_n = rst_v; play = play_v; direction = dir_v; restart = restart_v;
        sample_tick = tick_v; reader_finish = fin; reader_data = data;
        if (!rst_v) m_reset();
        else m_step(play_v, dir_v, restart_v, tick_v, fin, data);
        tick_v = 0;
        restart_v = 0;
    endtask

    task automatic wait_ready(input string name, input int bound);
        int k;
        k = 0;
        while (!(m_active && !m_issue && !m_busy && m_left == 2) && k < bound) begin
            step();
            k++;
        end
        if (k >= bound) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout got %0d cycles want <%0d", name, k, bound);
        end
    endtask

    task automatic wait_idle(input string name, input int bound);
        int k;
        k = 0;
        while (m_active && k < bound) begin step(); k++; end
        if (k >= bound) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout got %0d cycles want <%0d", name, k, bound);
        end
    endtask

    // Plays both halves of the next word; returns with the next fetch visible.
    task automatic emit_word();
        wait_ready("emit", 500);
        tick_v = 1; step();
        tick_v = 1; step();
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int base;
        rst_n = 0; play = 0; direction = 1; restart = 0; sample_tick = 0;
        reader_finish = 0; reader_data = 0;
        m_reset();

        // reset
        rst_v = 0; step(); step();
        check_lit("reset_addr", 32'(word_addr), 32'h0);
        check_lit("reset_out", 32'(sample_out), 32'h0);
        check_lit("reset_under", 32'(underrun_cnt), 32'h0);
        check_lit("reset_start", 32'(reader_start), 32'h0);

        // first word, two samples
        lat_v = 3; word_v = 32'hBBBB_AAAA;
        rst_v = 1; play_v = 1; step();
        start_cnt = 0;
        step();
        check_lit("first_start", 32'(reader_start), 32'h1);
        check_lit("first_addr", 32'(word_addr), 32'h0);
        check_lit("first_old", 32'(reader_addr_old), 32'h0);
        wait_ready("first", 50);
        tick_v = 1; step();
        tick_v = 1; step();
        check_lit("first_half", 32'({sample_valid, sample_out}), 32'h1AAAA);
        check_lit("one_start", 32'(start_cnt), 32'h1);
        step();
        check_lit("second_half", 32'({sample_valid, sample_out}), 32'h1BBBB);
        check_lit("next_fetch", 32'({reader_start, word_addr}), {8'h0, 1'b1, 23'h1});

        // underrun during a 10-cycle wait
        word_v = 32'h0102_0304; lat_v = 10;
        emit_word();
        valid_cnt = 0;
        tick_v = 1; step(); step();
        tick_v = 1; step(); step();
        tick_v = 1; step(); step();
        check_lit("under_3", 32'(underrun_cnt), 32'h3);
        check_lit("under_no_valid", 32'(valid_cnt), 32'h0);

        // saturation
        wait_ready("sat_pre", 50);
        lat_v = 400; word_v = 32'h5555_6666;
        emit_word();
        for (int i = 0; i < 300; i++) begin tick_v = 1; step(); end
        step();
        check_lit("under_sat", 32'(underrun_cnt), 32'hFF);

        // restart during wait discards the word
        wait_ready("rst_pre", 500);
        lat_v = 6; word_v = 32'hDEAD_BEEF;
        emit_word();
        check_lit("pre_restart_out", 32'(sample_out), 32'h5555);
        step();
        restart_v = 1; step();
        wait_idle("restart", 50);
        step();
        check_lit("restart_out", 32'(sample_out), 32'h5555);
        check_lit("restart_addr", 32'(word_addr), 32'(S_A));
        step();
        check_lit("restart_fetch", 32'({reader_start, reader_addr_old}), 32'h2);

        // pause in the second half
        wait_ready("pause", 50);
        tick_v = 1; step();
        play_v = 0;
        base = start_cnt;
        for (int i = 0; i < 6; i++) begin tick_v = 1; step(); end
        check_lit("pause_addr", 32'(word_addr), 32'(S_A));
        check_lit("pause_out", 32'(sample_out), 32'h0000_BEEF);
        check_lit("pause_nostart", 32'(start_cnt - base), 32'h0);
        play_v = 1; tick_v = 1; step(); step();
        check_lit("resume_half", 32'(sample_out), 32'h0000_DEAD);
        check_lit("resume_fetch", 32'({reader_start, word_addr}), {8'h0, 1'b1, 23'h1});

        // forward wrap at the region end
        lat_v = 2;
        for (int i = 0; i < 40 && m_addr != E_A; i++) emit_word();
        emit_word();
        check_lit("fwd_wrap", 32'({reader_start, word_addr}), {8'h0, 1'b1, S_A});

`ifdef SAMPLE_SEQUENCER_REVERSE_EN
        // reverse restart, halves, and wrap
        dir_v = 0;
        restart_v = 1; step();
        wait_idle("rev_restart", 50);
        step();
        check_lit("rev_restart_addr", 32'(word_addr), 32'(E_A));
        word_v = 32'h1234_5678;
        wait_ready("rev", 50);
        tick_v = 1; step();
        tick_v = 1; step();
        check_lit("rev_first", 32'(sample_out), 32'h1234);
        step();
        check_lit("rev_second", 32'(sample_out), 32'h5678);
        check_lit("rev_next", 32'(word_addr), 32'(E_A - 23'd1));
        for (int i = 0; i < 40 && m_addr != S_A; i++) emit_word();
        emit_word();
        check_lit("rev_wrap", 32'(word_addr), 32'(E_A));
        dir_v = 1;
        restart_v = 1; step();
        wait_idle("fwd_restart", 50);
        step();
`endif

        // reset in the middle of a fetch
        emit_word();
        step();
        rst_v = 0; step();
        rst_v = 1; step();
        check_lit("midrst_addr", 32'(word_addr), 32'(S_A));
        check_lit("midrst_under", 32'(underrun_cnt), 32'h0);
        step();
        check_lit("midrst_fetch", 32'({reader_start, reader_addr_old}), 32'h2);

        // randomized play
        stray_en = 1; rand_lat = 1; rand_word = 1;
        for (int ph = 0; ph < 6; ph++) begin
            dir_v = 1'($urandom);
            restart_v = 1; step();
            for (int i = 0; i < 600; i++) begin
                play_v    = ($urandom_range(0, 7) != 0);
                tick_v    = ($urandom_range(0, 3) == 0);
                restart_v = ($urandom_range(0, 63) == 0);
                rst_v     = ($urandom_range(0, 999) != 0);
                step();
            end
            rst_v = 1;
        end
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_sequencer.md
SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 Parameter START_ADDR, default 23'h000000, first 32-bit word address of the sample region.
REQ-002 Parameter END_ADDR, default 23'h07FFFF, last word address of the sample region (END_ADDR > START_ADDR).
REQ-003 Port clk  input  1  single clock; every flop is rising-edge triggered.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port play  input  1  level; 1 = run, 0 = pause.
REQ-006 Port direction  input  1  level; 1 = forward, 0 = reverse.
REQ-007 Port restart  input  1  one-cycle pulse; rewinds to the region start in the current direction.
REQ-008 Port sample_tick  input  1  one-cycle audio-rate strobe.
REQ-009 Port reader_start  output  1  one-cycle request to the flash word reader.
REQ-010 Port reader_addr_old  output  1  to the reader; high when the requested word equals the last fetched word.
REQ-011 Port reader_finish  input  1  one-cycle completion from the reader.
REQ-012 Port reader_data  input  32  word returned by the reader; valid while reader_finish = 1.
REQ-013 Port word_addr  output  23  current word address presented to the reader's address path.
REQ-014 Port sample_out  output  16  current audio sample.
REQ-015 Port sample_valid  output  1  one-cycle pulse when sample_out updates.
REQ-016 Port underrun_cnt  output  8  saturating count of ticks missed while fetching.

Function
REQ-017 States: IDLE, FETCH, WAIT, TICK0, TICK1.
REQ-018 IDLE -> FETCH when play = 1; otherwise remain in IDLE.
REQ-019 FETCH: reader_start = 1 for exactly this cycle; next state is WAIT.
REQ-020 reader_addr_old = 1 in FETCH iff last_valid = 1 and word_addr == last_addr.
REQ-021 WAIT: on reader_finish, latch reader_data into word_buf, set last_addr <= word_addr and last_valid <= 1, then go to TICK0.
REQ-022 reader_start is never asserted while in WAIT; there is at most one outstanding request.
REQ-023 TICK0: on sample_tick with play = 1, emit the first half and go to TICK1. The first half is word_buf[15:0] when forward and word_buf[31:16] when reverse.
REQ-024 TICK1: on sample_tick with play = 1, emit the other half, advance word_addr, then go to FETCH.
REQ-025 Emit: sample_out updates, and sample_valid pulses, in the cycle after the sample_tick that caused it (latency 1).
REQ-026 Advance forward: word_addr + 1, wrapping END_ADDR -> START_ADDR.
REQ-027 Advance reverse: word_addr - 1, wrapping START_ADDR -> END_ADDR.
REQ-028 direction is sampled at each emit and at each advance; a change takes effect at the next half or word boundary.
REQ-029 play = 0 in TICK0 or TICK1: hold state, ignore ticks, hold sample_out.
REQ-030 play = 0 in FETCH or WAIT: the transaction completes and the block then holds in TICK0.
REQ-031 sample_tick in FETCH or WAIT with play = 1 increments underrun_cnt, saturating at 8'hFF; no sample is emitted for that tick.
REQ-032 restart in IDLE, TICK0 or TICK1: word_addr <= START_ADDR (forward) or END_ADDR (reverse), last_valid <= 0, next state IDLE.
REQ-033 restart in FETCH or WAIT sets restart_pend.
REQ-034 When reader_finish arrives with restart_pend set, the data is discarded, the address is reloaded per REQ-032, restart_pend clears, and the next state is IDLE.
REQ-035 restart coincident with sample_tick: restart wins and no sample is emitted.
REQ-036 reader_finish outside WAIT is ignored.

Reset
REQ-037 rst_n = 0 forces, asynchronously: state IDLE, word_addr = START_ADDR, word_buf = 0, last_addr = 0, last_valid = 0, restart_pend = 0.
REQ-038 rst_n = 0 also forces, asynchronously: sample_out = 0, sample_valid = 0, reader_start = 0, reader_addr_old = 0, underrun_cnt = 0.
REQ-039 Reset mid-fetch abandons the transaction; the first request after reset is a fresh FETCH with reader_addr_old = 0.

Configuration
REQ-040 Macro SAMPLE_SEQUENCER_REVERSE_EN compiled in: direction behaves as in REQ-023 to REQ-028 and REQ-032.
REQ-041 Macro SAMPLE_SEQUENCER_REVERSE_EN absent: direction is ignored and treated as 1 (forward only); the reverse decrement logic is not built.

Verification
REQ-042 Reset, play = 1, reader returns 32'hBBBB_AAAA -> exactly one reader_start with word_addr = 0, then sample_out 16'hAAAA then 16'hBBBB on successive ticks, each sample_valid one cycle after its tick.
REQ-043 Forward play at word_addr = 23'h07FFFF, two ticks -> next FETCH issues word_addr = 23'h000000.
REQ-044 Reverse play, restart pulse -> word_addr = 23'h07FFFF.
REQ-045 Reverse play, reader returns 32'h1234_5678 -> sample_out 16'h1234 then 16'h5678; at word_addr = 0 the address wraps to 23'h07FFFF (macro defined).
REQ-046 Three ticks during a 10-cycle WAIT -> underrun_cnt = 3 and no sample_valid pulses; 300 such ticks -> underrun_cnt = 8'hFF.
REQ-047 restart during WAIT, reader_finish with 32'hDEAD_BEEF -> sample_out unchanged, word_addr = START_ADDR, next FETCH has reader_addr_old = 0. Pause in TICK1 and resume -> same word_addr with no new reader_start until the second half is emitted.
